// File: rtl/fir_requant_fifo_pkg.sv
// Shared constants, sample type and rounding/saturation helpers for the requant stage.
package fir_requant_fifo_pkg;

   localparam int SAT_CNT_W = 16;
   localparam int SAMPLE_W  = 16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   // Half-LSB rounding offset for an arithmetic shift; zero shift means no rounding.
   function automatic logic [63:0] sat_shift_rnd(input int shift);
      if (shift == 0) begin
         return 64'd0;
      end else begin
         return 64'd1 << (shift - 1);
      end
   endfunction

   function automatic logic [63:0] sat_shift_max(input int m);
      return (64'd1 << (m - 1)) - 64'd1;
   endfunction

endpackage

// File: rtl/fir_requant_fifo_if.sv
// Valid/ready sample stream from the requant FIFO to its consumer.
interface fir_requant_fifo_if #(
   parameter int M = 16
);
   logic signed [M-1:0] out_data;
   logic                out_valid;
   logic                out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fir_requant_fifo_sync_fifo.sv
// Single-clock circular FIFO with combinational head read; a push on full is
// accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_din,
   output logic [WIDTH-1:0]         o_dout,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == CW'(0));
   assign o_full    = (r_count == CW'(DEPTH));
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_dout    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fir_requant_fifo.sv
// Strobe-timed capture of fir_n output, round-half-up shift, saturation and FIFO buffering.
// Optional saturation event counter: define FIR_REQUANT_SATCNT_EN.
module fir_requant_fifo
   import fir_requant_fifo_pkg::*;
#(
   parameter int N     = 32,
   parameter int M     = 16,
   parameter int SHIFT = 10,
   parameter int DEPTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_ena,
   input  logic                    i_clk_d,
   input  logic signed [N-1:0]     i_y_in,
   fir_requant_fifo_if.master      o_stream,
   output logic [$clog2(DEPTH):0]  o_fifo_count,
   output logic                    o_overflow
`ifdef FIR_REQUANT_SATCNT_EN
   ,output logic [SAT_CNT_W-1:0]   o_sat_count
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int W1 = N + 1;
   localparam logic signed [N:0] RND  = W1'(sat_shift_rnd(SHIFT));
   localparam logic signed [N:0] MAXV = W1'(sat_shift_max(M));
   localparam logic signed [N:0] MINV = ~MAXV;

   logic                r_clk_d_q;
   logic                r_cap_v;
   logic                r_rq_v;
   logic                r_overflow;
   logic signed [N-1:0] r_cap;
   logic signed [M-1:0] r_rq;

   logic                w_strobe;
   logic signed [N:0]   w_t;
   logic signed [N:0]   w_r;
   logic signed [M-1:0] w_rq;
   logic                w_sat;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic [CW-1:0]       w_count;
   logic [M-1:0]        w_dout;

   assign w_strobe = i_clk_d & ~r_clk_d_q & i_ena;
   // One extra bit keeps the rounding add from wrapping at the top of the range.
   assign w_t      = $signed({r_cap[N-1], r_cap}) + RND;
   assign w_r      = w_t >>> SHIFT;

   always_comb begin
      w_rq  = w_r[M-1:0];
      w_sat = 1'b0;
      if (w_r > MAXV) begin
         w_rq  = MAXV[M-1:0];
         w_sat = 1'b1;
      end else if (w_r < MINV) begin
         w_rq  = MINV[M-1:0];
         w_sat = 1'b1;
      end else begin
         w_rq  = w_r[M-1:0];
         w_sat = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_clk_d_q  <= 1'b0;
         r_cap_v    <= 1'b0;
         r_rq_v     <= 1'b0;
         r_cap      <= '0;
         r_rq       <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_clk_d_q <= i_clk_d;
         r_cap_v   <= w_strobe;
         r_rq_v    <= r_cap_v;
         if (w_strobe) begin
            r_cap <= i_y_in;
         end
         if (r_cap_v) begin
            r_rq <= w_rq;
         end
         if (r_rq_v & w_full & ~w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

`ifdef FIR_REQUANT_SATCNT_EN
   logic [SAT_CNT_W-1:0] r_sat_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sat_count <= '0;
      end else if (r_cap_v & w_sat & (r_sat_count != {SAT_CNT_W{1'b1}})) begin
         r_sat_count <= r_sat_count + SAT_CNT_W'(1);
      end
   end

   assign o_sat_count = r_sat_count;
`endif

   sync_fifo #(
      .WIDTH (M),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (r_rq_v),
      .i_pop   (w_pop),
      .i_din   (r_rq),
      .o_dout  (w_dout),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_pop              = o_stream.out_valid & o_stream.out_ready;
   assign o_stream.out_valid = ~w_empty;
   assign o_stream.out_data  = $signed(w_dout);
   assign o_fifo_count       = w_count;
   assign o_overflow         = r_overflow;

endmodule

// File: tb/tb_fir_requant_fifo.sv
// Directed self-checking bench for fir_requant_fifo (N=32, M=16, SHIFT=10, DEPTH=8).
module tb_fir_requant_fifo;
   import fir_requant_fifo_pkg::*;

   localparam int N     = 32;
   localparam int M     = 16;
   localparam int SHIFT = 10;
   localparam int DEPTH = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic                ena;
   logic                clk_d;
   logic signed [N-1:0] y_in;
   logic [3:0]          fifo_count;
   logic                overflow;
`ifdef FIR_REQUANT_SATCNT_EN
   logic [15:0]         sat_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   fir_requant_fifo_if #(.M(M)) stream ();

   fir_requant_fifo #(
      .N(N), .M(M), .SHIFT(SHIFT), .DEPTH(DEPTH)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_ena        (ena),
      .i_clk_d      (clk_d),
      .i_y_in       (y_in),
      .o_stream     (stream),
      .o_fifo_count (fifo_count),
      .o_overflow   (overflow)
`ifdef FIR_REQUANT_SATCNT_EN
      ,.o_sat_count (sat_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; ena = 1'b1; clk_d = 1'b0; y_in = '0; stream.out_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Strobe one sample; on return it sits in the requant register, written next edge.
   task automatic send(input logic signed [N-1:0] v);
      y_in = v; clk_d = 1'b1;
      tick();
      clk_d = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
      n_cmp++; if (stream.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", stream.out_valid); end
      n_cmp++; if (stream.out_data !== 16'sd0) begin n_err++; $display("FAIL reset_data got=%0d exp=0", stream.out_data); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`ifdef FIR_REQUANT_SATCNT_EN
      n_cmp++; if (sat_count !== 16'd0) begin n_err++; $display("FAIL reset_satcnt got=%0d exp=0", sat_count); end
`endif
   endtask

   task automatic test_impulse();
      logic signed [N-1:0] vals [5] = '{32'sd193000, 32'sd376000, 32'sd376000, 32'sd193000, 32'sd0};
      sample_t             exps [5] = '{16'sd188, 16'sd367, 16'sd367, 16'sd188, 16'sd0};
      do_reset();
      stream.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         y_in = vals[i]; clk_d = 1'b1;
         tick();
         n_cmp++; if (stream.out_valid !== 1'b0) begin n_err++; $display("FAIL imp_lat1[%0d] valid got=%b exp=0", i, stream.out_valid); end
         clk_d = 1'b0;
         tick();
         n_cmp++; if (stream.out_valid !== 1'b0) begin n_err++; $display("FAIL imp_lat2[%0d] valid got=%b exp=0", i, stream.out_valid); end
         tick();
         n_cmp++; if (stream.out_valid !== 1'b1 || stream.out_data !== exps[i]) begin
            n_err++; $display("FAIL imp_out[%0d] got=%0d/v%b exp=%0d/v1", i, stream.out_data, stream.out_valid, exps[i]);
         end
      end
      tick();
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL imp_drained count got=%0d exp=0", fifo_count); end
   endtask

   task automatic test_rounding();
      logic signed [N-1:0] vals [4] = '{-32'sd1536, 32'sd512, 32'sd511, -32'sd513};
      sample_t             exps [4] = '{-16'sd1, 16'sd1, 16'sd0, -16'sd1};
      do_reset();
      stream.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(vals[i]);
         tick();
         n_cmp++; if (stream.out_valid !== 1'b1 || stream.out_data !== exps[i]) begin
            n_err++; $display("FAIL round[%0d] in=%0d got=%0d exp=%0d", i, vals[i], stream.out_data, exps[i]);
         end
      end
   endtask

   task automatic test_saturation();
      logic signed [N-1:0] vals [2] = '{32'sd40000000, -32'sd40000000};
      sample_t             exps [2] = '{16'sh7FFF, 16'sh8000};
      do_reset();
      stream.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         send(vals[i]);
         tick();
         n_cmp++; if (stream.out_valid !== 1'b1 || stream.out_data !== exps[i]) begin
            n_err++; $display("FAIL sat[%0d] got=%0d exp=%0d", i, stream.out_data, exps[i]);
         end
      end
`ifdef FIR_REQUANT_SATCNT_EN
      n_cmp++; if (sat_count !== 16'd2) begin n_err++; $display("FAIL sat_count got=%0d exp=2", sat_count); end
`endif
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int k = 1; k <= 9; k++) send(32'(1024 * k));
      tick();
      n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL bp_count got=%0d exp=8", fifo_count); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow got=%b exp=1", overflow); end
      stream.out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         n_cmp++; if (stream.out_valid !== 1'b1 || stream.out_data !== 16'(k)) begin
            n_err++; $display("FAIL bp_drain[%0d] got=%0d/v%b exp=%0d/v1", k, stream.out_data, stream.out_valid, k);
         end
         tick();
      end
      n_cmp++; if (stream.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_lost9 valid got=%b exp=0", stream.out_valid); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int k = 1; k <= 8; k++) send(32'(1024 * k));
      tick();
      n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL fp_pre count got=%0d exp=8", fifo_count); end
      y_in = 32'(1024 * 9); clk_d = 1'b1;
      tick();
      clk_d = 1'b0;
      tick();
      stream.out_ready = 1'b1;
      tick();
      stream.out_ready = 1'b0;
      n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL fp_count got=%0d exp=8", fifo_count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fp_overflow got=%b exp=0", overflow); end
      stream.out_ready = 1'b1;
      for (int k = 2; k <= 9; k++) begin
         n_cmp++; if (stream.out_valid !== 1'b1 || stream.out_data !== 16'(k)) begin
            n_err++; $display("FAIL fp_drain[%0d] got=%0d/v%b exp=%0d/v1", k, stream.out_data, stream.out_valid, k);
         end
         tick();
      end
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL fp_empty count got=%0d exp=0", fifo_count); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 1; k <= 9; k++) send(32'(1024 * k));
      tick();
      stream.out_ready = 1'b1;
      repeat (5) tick();
      stream.out_ready = 1'b0;
      n_cmp++; if (fifo_count !== 4'd3 || overflow !== 1'b1) begin
         n_err++; $display("FAIL rm_pre count=%0d ovf=%b exp=3/1", fifo_count, overflow);
      end
      y_in = 32'(1024 * 77); clk_d = 1'b1;
      tick();
      clk_d = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL rm_count got=%0d exp=0", fifo_count); end
      n_cmp++; if (stream.out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got=%b exp=0", stream.out_valid); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rm_overflow got=%b exp=0", overflow); end
      repeat (3) tick();
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL rm_inflight count got=%0d exp=0", fifo_count); end
      // A sample strobed just before ena drops still completes.
      y_in = 32'(1024 * 3); clk_d = 1'b1;
      tick();
      ena = 1'b0; clk_d = 1'b0;
      tick();
      tick();
      n_cmp++; if (fifo_count !== 4'd1 || stream.out_data !== 16'sd3) begin
         n_err++; $display("FAIL ena_drain count=%0d data=%0d exp=1/3", fifo_count, stream.out_data);
      end
      send(32'(1024 * 5));
      send(32'(1024 * 6));
      repeat (2) tick();
      n_cmp++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL ena_off count got=%0d exp=1", fifo_count); end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_rounding();
      test_saturation();
      test_backpressure();
      test_full_pop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
